hex_word_serializer: RTL and testbench

//  Streams a WIDTH-bit word as ASCII hex characters, one character per accepted beat, for UART/debug console output.
//  The block has a valid/ready input, a valid/ready byte output and an optional terminator character.
//  It sits between the core's debug/trace port and the UART TX byte FIFO.

---
 rtl/hex_ser_pkg.sv | 29 ++
 rtl/hex_digit_ascii.sv | 23 ++
 rtl/hex_word_serializer.sv | 194 +++++++++++++++++++
 tb/tb_hex_word_serializer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_ser_pkg.sv
// hex_ser_pkg
// Shared definitions for the hex word serializer:
//   - hex_ser_state_e : FSM state encoding
//   - ASCII_*         : character constants used to build output bytes
//   - ndig()          : number of hex digits needed for a given word width
// The prefix states only exist when HEX_SER_PREFIX_EN is defined.
package hex_ser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
`ifdef HEX_SER_PREFIX_EN
    ST_PFX0   = 3'd1,
    ST_PFX1   = 3'd2,
`endif
    ST_DIGITS = 3'd3,
    ST_TERM   = 3'd4
  } hex_ser_state_e;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_X  = 8'h78;

  // The most significant digit may be partial; it is zero-extended.
  function automatic int ndig(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/hex_digit_ascii.sv
// hex_digit_ascii
// Combinational nibble to ASCII hex character conversion.
// Ports:
//   nibble    in  4  value 0..15
//   lowercase in  1  1: 10..15 map to 'a'..'f', 0: 'A'..'F'
//   ascii     out 8  ASCII character
module hex_digit_ascii
  import hex_ser_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       lowercase,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_0 + {4'h0, nibble};
    end else begin
      ascii = (lowercase ? ASCII_LA : ASCII_UA) + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_word_serializer.sv
// hex_word_serializer
// Streams a WIDTH-bit word as ASCII hex characters, one byte per output
// handshake, optionally followed by a terminator byte.
// Ports:
//   clk       in   1      clock
//   rst       in   1      synchronous active-high reset
//   in_valid  in   1      in_data valid
//   in_ready  out  1      high only while idle
//   in_data   in   WIDTH  word to print
//   out_valid out  1      out_char valid
//   out_ready in   1      downstream accepts out_char
//   out_char  out  8      ASCII byte
//   out_last  out  1      final byte of the current word
//   busy      out  1      high whenever not idle
// Configuration macro:
//   HEX_SER_PREFIX_EN  when defined, "0x" is emitted before the digits.
module hex_word_serializer
  import hex_ser_pkg::*;
#(
  parameter int         WIDTH          = 32,
  parameter int         LOWERCASE      = 0,
  parameter int         SUPPRESS_ZEROS = 0,
  parameter int         EMIT_TERM      = 1,
  parameter logic [7:0] TERM_CHAR      = 8'h0A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy
);

  localparam int   NDIG    = ndig(WIDTH);
  localparam int   PADW    = NDIG * 4;
  localparam int   IDXW    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic TERM_EN = (EMIT_TERM != 0);

  hex_ser_state_e  state;
  logic [PADW-1:0] in_pad;
  logic [PADW-1:0] word;
  logic [PADW-1:0] sel_src;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] start_idx;
  logic [IDXW-1:0] sel_idx;
  logic [3:0]      sel_nibble;
  logic [7:0]      sel_ascii;
  logic            digit_is_last;

  assign in_pad = PADW'(in_data);

  // Leading-zero priority encoder: the highest non-zero nibble wins,
  // and an all-zero word still prints digit 0.
  always_comb begin
    start_idx = IDXW'(NDIG - 1);
    if (SUPPRESS_ZEROS != 0) begin
      start_idx = '0;
      for (int i = 0; i < NDIG; i++) begin
        if (in_pad[i*4 +: 4] != 4'h0) begin
          start_idx = IDXW'(i);
        end
      end
    end
  end

  // Outputs are registered, so the byte for the next beat is looked up
  // one step ahead: from the incoming word when idle, from the held
  // index after the prefix, and from the following index while printing.
  always_comb begin
    sel_src = word;
    sel_idx = idx - IDXW'(1);
    case (state)
      ST_IDLE: begin
        sel_src = in_pad;
        sel_idx = start_idx;
      end
`ifdef HEX_SER_PREFIX_EN
      ST_PFX0, ST_PFX1: begin
        sel_idx = idx;
      end
`endif
      default: begin
      end
    endcase
    sel_nibble = 4'h0;
    for (int i = 0; i < NDIG; i++) begin
      if (sel_idx == IDXW'(i)) begin
        sel_nibble = sel_src[i*4 +: 4];
      end
    end
  end

  // Digit 0 carries out_last only when no terminator follows it.
  assign digit_is_last = !TERM_EN && (sel_idx == '0);

  hex_digit_ascii u_digit (
    .nibble    (sel_nibble),
    .lowercase (LOWERCASE != 0),
    .ascii     (sel_ascii)
  );

  // Main FSM. Every non-idle state presents a valid byte, so a handshake
  // there reduces to out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      word      <= '0;
      idx       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            word      <= in_pad;
            idx       <= start_idx;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
`ifdef HEX_SER_PREFIX_EN
            state     <= ST_PFX0;
            out_char  <= ASCII_0;
            out_last  <= 1'b0;
`else
            state     <= ST_DIGITS;
            out_char  <= sel_ascii;
            out_last  <= digit_is_last;
`endif
          end
        end
`ifdef HEX_SER_PREFIX_EN
        ST_PFX0: begin
          if (out_ready) begin
            state    <= ST_PFX1;
            out_char <= ASCII_X;
          end
        end
        ST_PFX1: begin
          if (out_ready) begin
            state    <= ST_DIGITS;
            out_char <= sel_ascii;
            out_last <= digit_is_last;
          end
        end
`endif
        ST_DIGITS: begin
          if (out_ready) begin
            if (idx == '0) begin
              if (TERM_EN) begin
                state    <= ST_TERM;
                out_char <= TERM_CHAR;
                out_last <= 1'b1;
              end else begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
                in_ready  <= 1'b1;
              end
            end else begin
              idx      <= idx - IDXW'(1);
              out_char <= sel_ascii;
              out_last <= digit_is_last;
            end
          end
        end
        ST_TERM: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_word_serializer.sv
// tb_hex_word_serializer
// Three serializer instances share clock and reset:
//   a: WIDTH=32 defaults (uppercase, terminator)
//   b: WIDTH=32, SUPPRESS_ZEROS=1
//   c: WIDTH=10, LOWERCASE=1, EMIT_TERM=0 (partial top digit)
// Expected bytes are queued when a word is accepted and compared as the
// DUT hands bytes out. Honors HEX_SER_PREFIX_EN when it is defined.
module tb_hex_word_serializer;

  logic clk;
  logic rst;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a, busy_a;
  logic [31:0] in_data_a;
  logic [7:0]  out_char_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, busy_b;
  logic [31:0] in_data_b;
  logic [7:0]  out_char_b;
  logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_last_c, busy_c;
  logic [9:0]  in_data_c;
  logic [7:0]  out_char_c;

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  logic [8:0] q_c[$];
  logic [8:0] exp_a, exp_b, exp_c;
  int         pops_a;
  int         checks;
  int         errors;

  hex_word_serializer #(.WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_char(out_char_a), .out_last(out_last_a), .busy(busy_a)
  );

  hex_word_serializer #(.WIDTH(32), .SUPPRESS_ZEROS(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_char(out_char_b), .out_last(out_last_b), .busy(busy_b)
  );

  hex_word_serializer #(.WIDTH(10), .LOWERCASE(1), .EMIT_TERM(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_data(in_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .out_char(out_char_c), .out_last(out_last_c), .busy(busy_c)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case a wait is never satisfied.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Reference model: builds the byte sequence {last, char} for a word.
  task automatic pushExpected(input int which, input logic [31:0] word_in);
    int          width, nd, first;
    bit          lower, suppress, term;
    logic [31:0] word;
    logic [3:0]  nib;
    logic [7:0]  ch;
    logic [8:0]  seq[$];
    case (which)
      0:       begin width = 32; lower = 0; suppress = 0; term = 1; end
      1:       begin width = 32; lower = 0; suppress = 1; term = 1; end
      default: begin width = 10; lower = 1; suppress = 0; term = 0; end
    endcase
    word = word_in;
    if (width < 32) word = word & ((32'h1 << width) - 32'h1);
    nd = (width + 3) / 4;
    first = nd - 1;
    if (suppress) begin
      first = 0;
      for (int i = nd - 1; i >= 0; i--) begin
        if (word[4*i +: 4] != 4'h0) begin
          first = i;
          break;
        end
      end
    end
`ifdef HEX_SER_PREFIX_EN
    seq.push_back({1'b0, 8'h30});
    seq.push_back({1'b0, 8'h78});
`endif
    for (int i = first; i >= 0; i--) begin
      nib = word[4*i +: 4];
      if (nib < 4'd10) ch = 8'h30 + {4'h0, nib};
      else ch = (lower ? 8'h61 : 8'h41) + {4'h0, nib} - 8'd10;
      seq.push_back({(!term && i == 0), ch});
    end
    if (term) seq.push_back({1'b1, 8'h0A});
    foreach (seq[k]) begin
      case (which)
        0:       q_a.push_back(seq[k]);
        1:       q_b.push_back(seq[k]);
        default: q_c.push_back(seq[k]);
      endcase
    end
  endtask

  function automatic logic getReady(input int which);
    case (which)
      0:       return in_ready_a;
      1:       return in_ready_b;
      default: return in_ready_c;
    endcase
  endfunction

  function automatic logic getBusy(input int which);
    case (which)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic int qSize(input int which);
    case (which)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic setInput(input int which, input logic v, input logic [31:0] d);
    case (which)
      0:       begin in_valid_a = v; in_data_a = d; end
      1:       begin in_valid_b = v; in_data_b = d; end
      default: begin in_valid_c = v; in_data_c = d[9:0]; end
    endcase
  endtask

  // Called 1 ns after a rising edge. Offers a word, waits for the accept
  // edge and queues its expected bytes; returns 1 ns after that edge.
  task automatic applyStimulus(input int which, input logic [31:0] word, input bit hold);
    int n;
    n = 0;
    setInput(which, 1'b1, word);
    while (!getReady(which) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("accept_ready", {31'b0, getReady(which)}, 32'd1);
    if (getReady(which)) pushExpected(which, word);
    @(posedge clk); #1;
    if (!hold) setInput(which, 1'b0, word);
  endtask

  task automatic waitDone(input int which);
    int n;
    n = 0;
    while ((getBusy(which) || qSize(which) != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_busy", {31'b0, getBusy(which)}, 32'd0);
    checkOutput("drain_queue", qSize(which), 32'd0);
  endtask

  // Byte monitors: a byte counts when valid and ready are both high
  // just before the rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      checkOutput("a_byte_expected", {31'b0, q_a.size() != 0}, 32'd1);
      if (q_a.size() != 0) begin
        exp_a = q_a.pop_front();
        checkOutput("a_char", {24'b0, out_char_a}, {24'b0, exp_a[7:0]});
        checkOutput("a_last", {31'b0, out_last_a}, {31'b0, exp_a[8]});
      end
      pops_a++;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      checkOutput("b_byte_expected", {31'b0, q_b.size() != 0}, 32'd1);
      if (q_b.size() != 0) begin
        exp_b = q_b.pop_front();
        checkOutput("b_char", {24'b0, out_char_b}, {24'b0, exp_b[7:0]});
        checkOutput("b_last", {31'b0, out_last_b}, {31'b0, exp_b[8]});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_c && out_ready_c) begin
      checkOutput("c_byte_expected", {31'b0, q_c.size() != 0}, 32'd1);
      if (q_c.size() != 0) begin
        exp_c = q_c.pop_front();
        checkOutput("c_char", {24'b0, out_char_c}, {24'b0, exp_c[7:0]});
        checkOutput("c_last", {31'b0, out_last_c}, {31'b0, exp_c[8]});
      end
    end
  end

  // Directed sequence.
  initial begin
    int n;
    int base;
    checks = 0;
    errors = 0;
    pops_a = 0;
    rst = 1'b1;
    in_valid_a = 0; in_data_a = '0; out_ready_a = 1;
    in_valid_b = 0; in_data_b = '0; out_ready_b = 1;
    in_valid_c = 0; in_data_c = '0; out_ready_c = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_out_valid", {31'b0, out_valid_a}, 32'd0);
    checkOutput("rst_out_char", {24'b0, out_char_a}, 32'h0);
    checkOutput("rst_out_last", {31'b0, out_last_a}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy_a}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready_a}, 32'd1);

    $display("[TB] DEADBEEF with constant out_ready");
    applyStimulus(0, 32'hDEADBEEF, 0);
    n = 0;
    while (!(out_valid_a && out_last_a) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t1_last_char", {24'b0, out_char_a}, 32'h0A);
    @(posedge clk); #1;
    checkOutput("t1_in_ready_after", {31'b0, in_ready_a}, 32'd1);
    checkOutput("t1_valid_after", {31'b0, out_valid_a}, 32'd0);
    waitDone(0);

    $display("[TB] stall while 'A' is presented");
    applyStimulus(0, 32'hDEADBEEF, 0);
    n = 0;
    while (!(out_valid_a && out_char_a == 8'h41) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t2_found_A", {24'b0, out_char_a}, 32'h41);
    out_ready_a = 0;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("t2_hold_char", {24'b0, out_char_a}, 32'h41);
      checkOutput("t2_hold_valid", {31'b0, out_valid_a}, 32'd1);
    end
    out_ready_a = 1;
    waitDone(0);

    $display("[TB] zero suppression");
    applyStimulus(1, 32'h000000A5, 0);
    waitDone(1);
    applyStimulus(1, 32'h00000000, 0);
    waitDone(1);
    applyStimulus(1, 32'h80000000, 0);
    waitDone(1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, $urandom >> $urandom_range(0, 31), 0);
      waitDone(1);
    end

    $display("[TB] lowercase, no terminator, 10-bit word, in_valid held");
    applyStimulus(2, 32'h3EF, 1);
    in_data_c = 10'h155;
    n = 0;
    while (!in_ready_c && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid_c = 0;
    checkOutput("t4_ready_again", {31'b0, in_ready_c}, 32'd1);
    waitDone(2);
    applyStimulus(2, 32'h000, 0);
    waitDone(2);

    $display("[TB] reset mid-word");
    base = pops_a;
    applyStimulus(0, 32'hDEADBEEF, 0);
    n = 0;
    while (pops_a < base + 2 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q_a.delete();
    checkOutput("t5_valid_low", {31'b0, out_valid_a}, 32'd0);
    checkOutput("t5_in_ready", {31'b0, in_ready_a}, 32'd1);
    checkOutput("t5_busy_low", {31'b0, busy_a}, 32'd0);
    applyStimulus(0, 32'h00000001, 0);
    waitDone(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
